// File: rtl/metadata_fetch_scheduler.sv
// metadata_fetch_scheduler: round-robin refill of per-lane one-word metadata slots from one shared read port.
// Each lane reads sequentially from its own address window {lane, ptr}; supports pause, rewind and ack timeout.
module metadata_fetch_scheduler #(
    parameter int N_CH    = 37,
    parameter int DATA_W  = 16,
    parameter int CH_W    = 6,
    parameter int PTR_W   = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pause,
    input  logic                     rewind,
    input  logic [N_CH-1:0]          metadata_request,
    output logic [N_CH-1:0]          metadata_available,
    output logic [N_CH*DATA_W-1:0]   metadata_link,
    output logic                     mem_rd_req,
    output logic [CH_W+PTR_W-1:0]    mem_rd_addr,
    input  logic                     mem_rd_ack,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic                     timeout_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WRITE} state_t;

    state_t            state;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   pops;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   next_grant;
    logic [PTR_W-1:0]  ptr [N_CH];
    logic [DATA_W-1:0] slot [N_CH];
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              rewind_hold;
    logic              timed_out;
    logic              do_rewind;

    function automatic logic [CH_W-1:0] lane_after(input logic [CH_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        return CH_W'(s >= N_CH ? s - N_CH : s);
    endfunction

    // Scan downwards so the nearest pending lane after last_grant wins.
    always_comb begin
        next_grant = '0;
        for (int k = N_CH; k >= 1; k--)
            if (pending[lane_after(last_grant, k)]) next_grant = lane_after(last_grant, k);
    end

    assign pops      = metadata_request & metadata_available;
    assign timed_out = (state == ISSUE) && !mem_rd_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign do_rewind = (state == ISSUE) ? ((rewind || rewind_hold) && (mem_rd_ack || timed_out)) : rewind;

    for (genvar g = 0; g < N_CH; g++) begin : g_link
        assign metadata_link[g*DATA_W +: DATA_W] = slot[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            pending            <= '1;
            metadata_available <= '0;
            last_grant         <= CH_W'(N_CH - 1);
            grant              <= '0;
            data_q             <= '0;
            wait_cnt           <= '0;
            rewind_hold        <= 1'b0;
            mem_rd_req         <= 1'b0;
            mem_rd_addr        <= '0;
            timeout_err        <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ptr[i]  <= '0;
                slot[i] <= '0;
            end
        end else begin
            pending            <= pending | pops;
            metadata_available <= metadata_available & ~pops;
            case (state)
                IDLE: if (|pending && !pause && !rewind_hold && !rewind) begin
                    grant       <= next_grant;
                    mem_rd_addr <= {next_grant, ptr[next_grant]};
                    mem_rd_req  <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ISSUE;
                end
                ISSUE: if (mem_rd_ack) begin
                    mem_rd_req <= 1'b0;
                    data_q     <= mem_rd_data;
                    state      <= do_rewind ? IDLE : WRITE;
                end else if (timed_out) begin
                    mem_rd_req  <= 1'b0;
                    timeout_err <= 1'b1;
                    last_grant  <= grant;
                    state       <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (rewind) rewind_hold <= 1'b1;
                end
                WRITE: begin
                    if (!rewind) slot[grant] <= data_q;
                    metadata_available[grant] <= 1'b1;
                    pending[grant]            <= 1'b0;
                    ptr[grant]                <= ptr[grant] + 1'b1;
                    last_grant                <= grant;
                    state                     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Rewind overrides everything above, including a WRITE in the same cycle.
            if (do_rewind) begin
                metadata_available <= '0;
                pending            <= '1;
                last_grant         <= CH_W'(N_CH - 1);
                rewind_hold        <= 1'b0;
                for (int i = 0; i < N_CH; i++) ptr[i] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_metadata_fetch_scheduler.sv
// tb_metadata_fetch_scheduler: directed stimulus plus a transaction-level lane model checked every cycle.
module tb_metadata_fetch_scheduler;
    localparam int N  = 37;
    localparam int DW = 16;
    localparam int TO = 1023;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            pause;
    logic            rewind;
    logic [N-1:0]    metadata_request;
    logic [N-1:0]    metadata_available;
    logic [N*DW-1:0] metadata_link;
    logic            mem_rd_req;
    logic [15:0]     mem_rd_addr;
    logic            mem_rd_ack;
    logic [DW-1:0]   mem_rd_data;
    logic            timeout_err;

    int total = 0;
    int bad   = 0;

    metadata_fetch_scheduler dut (
        .clk(clk), .reset_n(reset_n), .pause(pause), .rewind(rewind),
        .metadata_request(metadata_request), .metadata_available(metadata_available),
        .metadata_link(metadata_link), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lane_word(input int lane, input int p);
        return 16'(lane * 1024 + p);
    endfunction

    function automatic logic [DW-1:0] link_of(input int lane);
        return metadata_link[lane*DW +: DW];
    endfunction

    // Memory responder: acks once the request has been up for more than ack_delay samples; data = address.
    logic        ack_en    = 1'b1;
    int          ack_delay = 0;
    logic [15:0] addr_log[$];
    initial begin
        int rcnt = 0;
        mem_rd_ack  = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_rd_req) begin
                rcnt++;
                if (rcnt == 1) addr_log.push_back(mem_rd_addr);
                mem_rd_ack  = ack_en && (rcnt > ack_delay);
                mem_rd_data = mem_rd_addr;
            end else begin
                rcnt       = 0;
                mem_rd_ack = 1'b0;
            end
        end
    end

    // Lane model: slot contents, availability, pending set, pointers and round-robin order.
    logic [N-1:0] m_avail, m_pend;
    logic [15:0]  m_link [N];
    logic [9:0]   m_ptr  [N];
    int           m_last;
    logic         m_terr, m_hold;
    logic         req_active, expect_low, wb, cand_ok;
    int           wcnt, wb_lane;
    logic [15:0]  wb_data, cur_addr, cand_addr;

    function automatic int rr_pick(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++)
            if (p[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            m_avail = '0; m_pend = '1; m_last = N - 1; m_terr = 1'b0; m_hold = 1'b0;
            req_active = 1'b0; expect_low = 1'b0; wb = 1'b0; wcnt = 0; cand_ok = 1'b0;
            cand_addr = '0; cur_addr = '0; wb_lane = 0; wb_data = '0;
            for (int i = 0; i < N; i++) begin m_link[i] = '0; m_ptr[i] = '0; end
        end else begin
            logic [N*DW-1:0] exp_link;
            logic            rw_now;
            int              l;
            for (int i = 0; i < N; i++) exp_link[i*DW +: DW] = m_link[i];
            total += 3;
            if (metadata_available !== m_avail) begin
                bad++; $display("FAIL model_avail got=%h exp=%h t=%0t", metadata_available, m_avail, $time);
            end
            if (metadata_link !== exp_link) begin
                bad++; $display("FAIL model_link got=%h exp=%h t=%0t", metadata_link, exp_link, $time);
            end
            if (timeout_err !== m_terr) begin
                bad++; $display("FAIL model_terr got=%b exp=%b t=%0t", timeout_err, m_terr, $time);
            end
            if (expect_low) begin
                chk("model_req_drop", 32'(mem_rd_req), 0);
                expect_low = 1'b0;
            end else if (mem_rd_req && !req_active) begin
                chk("model_grant_valid", 32'(cand_ok), 1);
                chk("model_grant_addr", 32'(mem_rd_addr), 32'(cand_addr));
                req_active = 1'b1; cur_addr = mem_rd_addr; wcnt = 0;
            end else if (req_active) begin
                chk("model_addr_stable", 32'(mem_rd_addr), 32'(cur_addr));
            end
            l         = rr_pick(m_pend, m_last);
            cand_ok   = |m_pend;
            cand_addr = {6'(l), m_ptr[l]};
            rw_now    = 1'b0;
            for (int i = 0; i < N; i++)
                if (metadata_request[i] && m_avail[i]) begin m_avail[i] = 1'b0; m_pend[i] = 1'b1; end
            if (wb) begin
                wb = 1'b0;
                if (!rewind) begin
                    m_link[wb_lane] = wb_data; m_avail[wb_lane] = 1'b1; m_pend[wb_lane] = 1'b0;
                    m_ptr[wb_lane] = m_ptr[wb_lane] + 10'd1; m_last = wb_lane;
                end
            end
            if (req_active && mem_rd_req) begin
                if (mem_rd_ack) begin
                    req_active = 1'b0; expect_low = 1'b1;
                    if (m_hold || rewind) rw_now = 1'b1;
                    else begin wb = 1'b1; wb_lane = int'(cur_addr[15:10]); wb_data = mem_rd_data; end
                end else begin
                    wcnt++;
                    if (wcnt == TO) begin
                        req_active = 1'b0; expect_low = 1'b1; m_terr = 1'b1; m_last = int'(cur_addr[15:10]);
                        if (m_hold || rewind) rw_now = 1'b1;
                    end else if (rewind) m_hold = 1'b1;
                end
            end else if (rewind) rw_now = 1'b1;
            if (rw_now) begin
                m_avail = '0; m_pend = '1; m_last = N - 1; m_hold = 1'b0;
                for (int i = 0; i < N; i++) m_ptr[i] = '0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n, rq;
        int rise [N];
        reset_n = 1'b0; pause = 1'b0; rewind = 1'b0; metadata_request = '0;
        repeat (3) tick();
        chk("rst_avail", 32'(|metadata_available), 0);
        chk("rst_link", 32'(|metadata_link), 0);
        chk("rst_req", 32'(mem_rd_req), 0);
        chk("rst_addr", 32'(mem_rd_addr), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        reset_n = 1'b1;

        // Initial prefetch: lanes fill in order, 3 cycles apart, data = {lane, 0}.
        t = 0;
        for (int i = 0; i < N; i++) begin
            n = 0;
            while (!metadata_available[i] && n < 20) begin tick(); t++; n++; end
            rise[i] = t;
        end
        chk("fill_first_latency", 32'(rise[0]), 3);
        for (int i = 1; i < N; i++) chk("fill_spacing", 32'(rise[i] - rise[i-1]), 3);
        for (int i = 0; i < N; i++) chk("fill_link", 32'(link_of(i)), 32'(lane_word(i, 0)));

        // Two pops in one cycle: round-robin from lane 36 serves lane 2 before lane 5.
        metadata_request = (N'(1) << 5) | (N'(1) << 2);
        tick();
        metadata_request = '0;
        n = 0;
        while (!(metadata_available[2] && metadata_available[5]) && n < 20) begin tick(); n++; end
        chk("rr_first_addr", 32'(addr_log[addr_log.size()-2]), 2049);
        chk("rr_second_addr", 32'(addr_log[addr_log.size()-1]), 5121);
        chk("rr_link2", 32'(link_of(2)), 2049);
        chk("rr_link5", 32'(link_of(5)), 5121);

        // Pause holds back the refill; release gives the word 3 cycles later.
        pause = 1'b1;
        tick();
        metadata_request = N'(1) << 3;
        tick();
        metadata_request = '0;
        rq = 0;
        repeat (10) begin tick(); if (mem_rd_req) rq++; end
        chk("pause_no_req", 32'(rq), 0);
        chk("pause_avail3", 32'(metadata_available[3]), 0);
        pause = 1'b0;
        tick(); tick();
        chk("unpause_2cyc", 32'(metadata_available[3]), 0);
        tick();
        chk("unpause_3cyc", 32'(metadata_available[3]), 1);
        chk("unpause_link3", 32'(link_of(3)), 32'(lane_word(3, 1)));

        // Ack withheld: request stays up TIMEOUT cycles, then the same lane is retried.
        ack_en = 1'b0;
        metadata_request = N'(1) << 7;
        tick();
        metadata_request = '0;
        n = 0;
        while (!mem_rd_req && n < 10) begin tick(); n++; end
        n = 0;
        while (mem_rd_req && n < 1100) begin n++; tick(); end
        chk("timeout_req_cycles", 32'(n), 1023);
        chk("timeout_err_set", 32'(timeout_err), 1);
        ack_en = 1'b1;
        n = 0;
        while (!mem_rd_req && n < 10) begin tick(); n++; end
        chk("timeout_retry_addr", 32'(mem_rd_addr), 7169);
        n = 0;
        while (!metadata_available[7] && n < 20) begin tick(); n++; end
        chk("timeout_retry_done", 32'(metadata_available[7]), 1);

        // Rewind while a read is in flight: data discarded, refill restarts at {0,0}.
        ack_delay = 4;
        metadata_request = N'(1) << 9;
        tick();
        metadata_request = '0;
        n = 0;
        while (!mem_rd_req && n < 10) begin tick(); n++; end
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        n = 0;
        while (mem_rd_req && n < 20) begin tick(); n++; end
        chk("rewind_avail_clear", 32'(|metadata_available), 0);
        chk("rewind_terr_kept", 32'(timeout_err), 1);
        ack_delay = 0;
        n = 0;
        while (!mem_rd_req && n < 10) begin tick(); n++; end
        chk("rewind_restart_addr", 32'(mem_rd_addr), 0);
        n = 0;
        while (metadata_available != '1 && n < 200) begin tick(); n++; end
        chk("rewind_refill_all", 32'(metadata_available == '1), 1);
        chk("rewind_link9", 32'(link_of(9)), 9216);
        chk("rewind_link36", 32'(link_of(36)), 36864);

        // 1024 pops of lane 0 walk its pointer through 1023 and back to 0.
        for (int k = 0; k < 1024; k++) begin
            n = 0;
            while (!metadata_available[0] && n < 10) begin tick(); n++; end
            metadata_request = N'(1);
            tick();
            metadata_request = '0;
        end
        n = 0;
        while (!metadata_available[0] && n < 10) begin tick(); n++; end
        chk("wrap_addr_1023", 32'(addr_log[addr_log.size()-2]), 1023);
        chk("wrap_addr_0", 32'(addr_log[addr_log.size()-1]), 0);
        chk("wrap_link0", 32'(link_of(0)), 0);

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
